// File: rtl/pn_dac_tx.sv
// pn_dac_tx: sample-pair FIFO feeding a two-stage round/saturate pipeline that
// drives offset-binary 14-bit codes to the RedPitaya DAC.
// Optional feature macro: PN_DAC_UNDERRUN_CNT_EN adds the OutUnderCnt port, a
// saturating count of underrun pulses.
module pn_dac_tx #(
  parameter int unsigned DTAWDTH   = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PRIME_LVL = 4
) (
  input  logic               DacClk,
  input  logic               DacRstn,
  input  logic               InEnable,
  input  logic [DTAWDTH-1:0] InDacA,
  input  logic [DTAWDTH-1:0] InDacB,
  input  logic               InValid,
  output logic               OutReady,
  output logic [13:0]        OutDacA,
  output logic [13:0]        OutDacB,
  output logic               OutUnderrun
`ifdef PN_DAC_UNDERRUN_CNT_EN
  ,
  output logic [15:0]        OutUnderCnt
`endif
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PAIR_W = 2 * DTAWDTH;
  localparam int unsigned S_W    = DTAWDTH + 1;
  localparam int unsigned OUT_W  = 14;
  localparam logic [OUT_W-1:0] MIDSCALE = 14'h2000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [PAIR_W-1:0] mem [DEPTH];
  logic [PAIR_W-1:0] pop_q;
  logic [OUT_W-1:0]  fmt_a_q, fmt_b_q;
  logic              wr_c, pop_c, und_c;

  // Round half up at bit 1, keep the top 14 bits, clamp to signed 14-bit range.
  function automatic logic [OUT_W-1:0] fmt_code(input logic [DTAWDTH-1:0] x);
    logic [S_W-1:0] s;
    s = {x[DTAWDTH-1], x} + S_W'(2);
    if (s[S_W-1] != s[S_W-2]) begin
      fmt_code = s[S_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      fmt_code = s[DTAWDTH-1 -: OUT_W];
    end
  endfunction

  assign OutReady = InEnable & (count_q < CNT_W'(DEPTH));
  assign wr_c     = InValid & OutReady;

  // State register.
  always_ff @(posedge DacClk or negedge DacRstn) begin
    if (!DacRstn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state, pop and underrun decisions.
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    und_c   = 1'b0;
    if (!InEnable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_PRIME;
        ST_PRIME: if (count_q >= CNT_W'(PRIME_LVL)) state_d = ST_RUN;
        ST_RUN: begin
          if (count_q == '0) begin
            state_d = ST_PRIME;
            und_c   = 1'b1;
          end else begin
            pop_c = 1'b1;
          end
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Fill level; a simultaneous write and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (!InEnable)          count_d = '0;
    else if (wr_c && !pop_c) count_d = count_q + CNT_W'(1);
    else if (!wr_c && pop_c) count_d = count_q - CNT_W'(1);
  end

  // FIFO level and pointers, flushed whenever streaming is disabled.
  always_ff @(posedge DacClk or negedge DacRstn) begin
    if (!DacRstn) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      count_q <= count_d;
      if (!InEnable) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr_c)  wptr_q <= wptr_q + PTR_W'(1);
        if (pop_c) rptr_q <= rptr_q + PTR_W'(1);
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge DacClk) begin
    if (wr_c) mem[wptr_q] <= {InDacA, InDacB};
  end

  // Pop -> format -> output pipeline; idle cycles carry a zero sample.
  always_ff @(posedge DacClk or negedge DacRstn) begin
    if (!DacRstn) begin
      pop_q   <= '0;
      fmt_a_q <= '0;
      fmt_b_q <= '0;
      OutDacA <= MIDSCALE;
      OutDacB <= MIDSCALE;
    end else if (!InEnable) begin
      pop_q   <= '0;
      fmt_a_q <= '0;
      fmt_b_q <= '0;
      OutDacA <= MIDSCALE;
      OutDacB <= MIDSCALE;
    end else begin
      pop_q   <= pop_c ? mem[rptr_q] : '0;
      fmt_a_q <= fmt_code(pop_q[PAIR_W-1 -: DTAWDTH]);
      fmt_b_q <= fmt_code(pop_q[DTAWDTH-1:0]);
      OutDacA <= {~fmt_a_q[OUT_W-1], fmt_a_q[OUT_W-2:0]};
      OutDacB <= {~fmt_b_q[OUT_W-1], fmt_b_q[OUT_W-2:0]};
    end
  end

  // One-cycle underrun pulse.
  always_ff @(posedge DacClk or negedge DacRstn) begin
    if (!DacRstn) OutUnderrun <= 1'b0;
    else          OutUnderrun <= und_c;
  end

`ifdef PN_DAC_UNDERRUN_CNT_EN
  // Saturating underrun counter, cleared only by reset.
  always_ff @(posedge DacClk or negedge DacRstn) begin
    if (!DacRstn)                        OutUnderCnt <= '0;
    else if (und_c && (OutUnderCnt != 16'hFFFF)) OutUnderCnt <= OutUnderCnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pn_dac_tx.sv
// Bench for pn_dac_tx: default instance plus a PRIME_LVL=DEPTH instance, both
// compared every cycle against a queue-based reference model.
module tb_pn_dac_tx;

  localparam int DEPTH  = 8;
  localparam int PW     = 3;
  localparam int PRIME0 = 4;
  localparam int MIDC   = 32'h2000;
  localparam int PH_IDLE = 0, PH_PRIME = 1, PH_RUN = 2;

  logic        DacClk, DacRstn, InEnable, InValid;
  logic [15:0] InDacA, InDacB;
  logic        rdy0, rdy1, und0, und1;
  logic [13:0] oa0, ob0, oa1, ob1;
`ifdef PN_DAC_UNDERRUN_CNT_EN
  logic [15:0] cnt0, cnt1;
`endif

  pn_dac_tx u_dut (
    .DacClk(DacClk), .DacRstn(DacRstn), .InEnable(InEnable),
    .InDacA(InDacA), .InDacB(InDacB), .InValid(InValid),
    .OutReady(rdy0), .OutDacA(oa0), .OutDacB(ob0), .OutUnderrun(und0)
`ifdef PN_DAC_UNDERRUN_CNT_EN
    , .OutUnderCnt(cnt0)
`endif
  );

  pn_dac_tx #(.DTAWDTH(16), .DEPTH(DEPTH), .PRIME_LVL(DEPTH)) u_bp (
    .DacClk(DacClk), .DacRstn(DacRstn), .InEnable(InEnable),
    .InDacA(InDacA), .InDacB(InDacB), .InValid(InValid),
    .OutReady(rdy1), .OutDacA(oa1), .OutDacB(ob1), .OutUnderrun(und1)
`ifdef PN_DAC_UNDERRUN_CNT_EN
    , .OutUnderCnt(cnt1)
`endif
  );

  always #5 DacClk = ~DacClk;

  int n_cmp = 0;
  int n_err = 0;
  bit last_rdy1;

  // Reference model state, one slot per instance.
  int m_size[2], m_head[2], m_ph[2], m_und[2], m_cnt[2];
  int m_d1a[2], m_d1b[2], m_d2a[2], m_d2b[2], m_oa[2], m_ob[2];
  logic [15:0] m_bufa[2][DEPTH];
  logic [15:0] m_bufb[2][DEPTH];

  function automatic int fmt(input logic [15:0] x);
    int v;
    v = int'($signed(x)) + 2;
    v = v >>> 2;
    if (v > 8191) v = 8191;
    if (v < -8192) v = -8192;
    return v + 8192;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset(input int i);
    m_size[i] = 0; m_head[i] = 0; m_ph[i] = PH_IDLE; m_und[i] = 0; m_cnt[i] = 0;
    m_d1a[i] = MIDC; m_d1b[i] = MIDC; m_d2a[i] = MIDC; m_d2b[i] = MIDC;
    m_oa[i] = MIDC; m_ob[i] = MIDC;
  endtask

  task automatic model_edge(input int i, input int pl, input bit en, input bit vld,
                            input logic [15:0] a, input logic [15:0] b);
    bit rdy, pop, und;
    rdy = en && (m_size[i] < DEPTH);
    pop = 0;
    und = 0;
    if (!en) begin
      m_size[i] = 0; m_head[i] = 0; m_ph[i] = PH_IDLE;
      m_d1a[i] = MIDC; m_d1b[i] = MIDC; m_d2a[i] = MIDC; m_d2b[i] = MIDC;
      m_oa[i] = MIDC; m_ob[i] = MIDC;
    end else begin
      case (m_ph[i])
        PH_IDLE:  m_ph[i] = PH_PRIME;
        PH_PRIME: if (m_size[i] >= pl) m_ph[i] = PH_RUN;
        default: begin
          if (m_size[i] == 0) begin m_ph[i] = PH_PRIME; und = 1; end
          else pop = 1;
        end
      endcase
      m_oa[i] = m_d2a[i]; m_ob[i] = m_d2b[i];
      m_d2a[i] = m_d1a[i]; m_d2b[i] = m_d1b[i];
      m_d1a[i] = pop ? fmt(m_bufa[i][PW'(m_head[i])]) : MIDC;
      m_d1b[i] = pop ? fmt(m_bufb[i][PW'(m_head[i])]) : MIDC;
      if (pop) begin
        m_head[i] = (m_head[i] + 1) % DEPTH;
        m_size[i]--;
      end
      if (vld && rdy) begin
        m_bufa[i][PW'((m_head[i] + m_size[i]) % DEPTH)] = a;
        m_bufb[i][PW'((m_head[i] + m_size[i]) % DEPTH)] = b;
        m_size[i]++;
      end
    end
    m_und[i] = und;
    if (und && m_cnt[i] < 65535) m_cnt[i]++;
  endtask

  task automatic check_outs();
    chk("dacA0", 32'(oa0), 32'(m_oa[0]));
    chk("dacB0", 32'(ob0), 32'(m_ob[0]));
    chk("under0", 32'(und0), 32'(m_und[0]));
    chk("dacA1", 32'(oa1), 32'(m_oa[1]));
    chk("dacB1", 32'(ob1), 32'(m_ob[1]));
    chk("under1", 32'(und1), 32'(m_und[1]));
`ifdef PN_DAC_UNDERRUN_CNT_EN
    chk("ucnt0", 32'(cnt0), 32'(m_cnt[0]));
    chk("ucnt1", 32'(cnt1), 32'(m_cnt[1]));
`endif
  endtask

  // One clock: drive, check ready before the edge, advance model, check outputs.
  task automatic step(input bit en, input bit vld, input logic [15:0] a, input logic [15:0] b);
    InEnable = en; InValid = vld; InDacA = a; InDacB = b;
    #1;
    chk("ready0", 32'(rdy0), 32'(en && (m_size[0] < DEPTH)));
    chk("ready1", 32'(rdy1), 32'(en && (m_size[1] < DEPTH)));
    last_rdy1 = rdy1;
    @(posedge DacClk);
    model_edge(0, PRIME0, en, vld, a, b);
    model_edge(1, DEPTH, en, vld, a, b);
    #1;
    check_outs();
  endtask

  task automatic rand_steps(input int n, input int pct);
    for (int k = 0; k < n; k++)
      step(1'b1, 1'($urandom_range(0, 99) < pct), 16'($urandom), 16'($urandom));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr;
    bit stop, hit;
    DacClk = 0; DacRstn = 0; InEnable = 0; InValid = 0; InDacA = '0; InDacB = '0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge DacClk);
    #1;
    check_outs();
    DacRstn = 1;

    // Disabled: never ready, midscale output.
    for (int k = 0; k < 16; k++)
      step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));

    // Four small samples stream through, then underrun.
    step(1'b1, 1'b1, 16'h0004, 16'h0100);
    step(1'b1, 1'b1, 16'h0008, 16'hFF00);
    step(1'b1, 1'b1, 16'h000C, 16'h0002);
    step(1'b1, 1'b1, 16'h0010, 16'hFFFE);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 16'($urandom), 16'($urandom));

    // Saturation and rounding extremes.
    step(1'b1, 1'b1, 16'h7FFF, 16'h8000);
    step(1'b1, 1'b1, 16'h7FFE, 16'h8001);
    step(1'b1, 1'b1, 16'h0000, 16'hFFFD);
    step(1'b1, 1'b1, 16'h8002, 16'h7FFD);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 16'($urandom), 16'($urandom));

    // Back-pressure on the PRIME_LVL=DEPTH instance.
    step(1'b0, 1'b0, 16'h0, 16'h0);
    nwr = 0;
    stop = 0;
    for (int k = 0; k < 30; k++) begin
      if (!stop) begin
        step(1'b1, 1'b1, 16'($urandom), 16'($urandom));
        if (last_rdy1) nwr++;
        else stop = 1;
      end
    end
    chk("bp_writes", 32'(nwr), 32'(DEPTH));
    for (int k = 0; k < 15; k++) step(1'b1, 1'b1, 16'($urandom), 16'($urandom));
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 16'($urandom), 16'($urandom));

    // Disable in RUN with five pairs queued, then restart from fresh data.
    step(1'b0, 1'b0, 16'h0, 16'h0);
    hit = 0;
    for (int k = 0; k < 30; k++) begin
      if (!hit) begin
        step(1'b1, 1'b1, 16'($urandom), 16'($urandom));
        if (m_size[0] == 5 && m_ph[0] == PH_RUN) hit = 1;
      end
    end
    chk("reach_run5", 32'(hit), 32'd1);
    step(1'b0, 1'b1, 16'h1234, 16'h4321);
    chk("flushA", 32'(oa0), 32'h2000);
    rand_steps(40, 60);

    // Sparse input to provoke repeated underruns.
    rand_steps(60, 25);

    // Asynchronous reset while streaming.
    hit = 0;
    for (int k = 0; k < 30; k++) begin
      if (!hit) begin
        step(1'b1, 1'b1, 16'($urandom), 16'($urandom));
        if (m_ph[0] == PH_RUN && m_size[0] > 0 && m_d2a[0] != MIDC) hit = 1;
      end
    end
    chk("reach_run", 32'(hit), 32'd1);
    #3;
    DacRstn = 0;
    #1;
    model_reset(0);
    model_reset(1);
    check_outs();
    chk("rst_ready0", 32'(rdy0), 32'd1);
    @(posedge DacClk);
    #1;
    check_outs();
    DacRstn = 1;
    rand_steps(40, 70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
